// File: rtl/param_hasher_if.sv
// Sample/hash handshake bundle between the time source and param_hasher.
// The master side drives start/seed and samples; the slave side returns the hash.
interface param_hasher_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] seed_id;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] cur_time;
  logic         out_valid;
  logic [W-1:0] cur_hash;
  logic [15:0]  step_cnt;

  modport master (
    output start, seed_id, in_valid, cur_time,
    input  in_ready, out_valid, cur_hash, step_cnt
  );

  modport slave (
    input  start, seed_id, in_valid, cur_time,
    output in_ready, out_valid, cur_hash, step_cnt
  );
endinterface

// File: rtl/param_hasher.sv
// Folds time samples into a W-bit hash chained through a DEPTH-entry history.
// Optional HASHER_TIME_CHECK_EN adds time_err and drops non-increasing samples.
module param_hasher #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int MULT  = 5
) (
  input  logic            clk,
  input  logic            rst,
  param_hasher_if.slave   bus
`ifdef HASHER_TIME_CHECK_EN
  , output logic          time_err
`endif
);
  localparam int PW = W + 33;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                    state, state_nxt;
  logic                      take_start, load;
  logic                      accept, time_ok, hash_en;
  logic [W-1:0]              seed_reg;
  logic [DEPTH-1:0][W-1:0]   hist;
  logic [W-1:0]              hash_new;
  logic [W-1:0]              cur_hash;
  logic [15:0]               step_cnt;
  logic                      out_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt  = LOAD;
        take_start = 1'b1;
      end
      LOAD: begin
        state_nxt = RUN;
        load      = 1'b1;
      end
      RUN: if (bus.start) begin
        state_nxt  = LOAD;
        take_start = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // start in RUN masks the same-cycle sample
  assign bus.in_ready = (state == RUN) & ~bus.start;
  assign accept       = bus.in_valid & bus.in_ready;
  assign hash_en      = accept & time_ok;

`ifdef HASHER_TIME_CHECK_EN
  logic [W-1:0] last_time;
  logic         first;

  // first sample after LOAD is always in order, even t=0
  assign time_ok = first | (bus.cur_time > last_time);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_time <= '0;
      first     <= 1'b0;
      time_err  <= 1'b0;
    end else if (load) begin
      last_time <= '0;
      first     <= 1'b1;
      time_err  <= 1'b0;
    end else if (accept) begin
      if (time_ok) begin
        last_time <= bus.cur_time;
        first     <= 1'b0;
      end else begin
        time_err  <= 1'b1;
      end
    end
  end
`else
  assign time_ok = 1'b1;
`endif

  // full-width product and sum, keep only the low W bits
  assign hash_new = W'(PW'(hist[DEPTH-1] ^ bus.cur_time) * PW'(MULT) + PW'(seed_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_reg  <= '0;
      hist      <= '0;
      cur_hash  <= '0;
      step_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= hash_en;
      if (take_start) seed_reg <= bus.seed_id;
      if (load) begin
        for (int i = 0; i < DEPTH; i++) hist[i] <= seed_reg;
        cur_hash <= seed_reg;
        step_cnt <= '0;
      end else if (hash_en) begin
        for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0]  <= hash_new;
        cur_hash <= hash_new;
        if (step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.cur_hash  = cur_hash;
  assign bus.step_cnt  = step_cnt;
endmodule

// File: tb/tb_param_hasher.sv
// Bench for param_hasher: DEPTH=4 and DEPTH=1 instances driven in lockstep
// and compared against a transaction-level model of the hash chain.
module tb_param_hasher;
  localparam int W    = 16;
  localparam int MULT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_hasher_if #(.W(W)) b4 ();
  param_hasher_if #(.W(W)) b1 ();

`ifdef HASHER_TIME_CHECK_EN
  logic terr4, terr1;
`endif

  param_hasher #(.W(W), .DEPTH(4), .MULT(MULT)) dut4 (
    .clk(clk), .rst(rst), .bus(b4)
`ifdef HASHER_TIME_CHECK_EN
    , .time_err(terr4)
`endif
  );

  param_hasher #(.W(W), .DEPTH(1), .MULT(MULT)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
`ifdef HASHER_TIME_CHECK_EN
    , .time_err(terr1)
`endif
  );

  int tests = 0;
  int fails = 0;

  // model: mode 0 idle, 1 loading, 2 running
  int           depth [2] = '{4, 1};
  int           mmode;
  logic [W-1:0] mseed;
  logic [W-1:0] mh    [2][4];
  logic [W-1:0] mhash [2];
  logic [15:0]  mcnt  [2];
  logic         mov;
  logic [W-1:0] mlast;
  logic         mfirst;
  logic         mterr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mmode = 0; mseed = '0; mov = 1'b0;
    mlast = '0; mfirst = 1'b0; mterr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mhash[d] = '0; mcnt[d] = '0;
      for (int k = 0; k < 4; k++) mh[d][k] = '0;
    end
  endtask

  task automatic drive(input logic s, input logic [W-1:0] sd, input logic v, input logic [W-1:0] t);
    b4.start = s; b4.seed_id = sd; b4.in_valid = v; b4.cur_time = t;
    b1.start = s; b1.seed_id = sd; b1.in_valid = v; b1.cur_time = t;
  endtask

  task automatic check_outputs();
    chk("out_valid4", 32'(b4.out_valid), 32'(mov));
    chk("out_valid1", 32'(b1.out_valid), 32'(mov));
    chk("cur_hash4", 32'(b4.cur_hash), 32'(mhash[0]));
    chk("cur_hash1", 32'(b1.cur_hash), 32'(mhash[1]));
    chk("step_cnt4", 32'(b4.step_cnt), 32'(mcnt[0]));
    chk("step_cnt1", 32'(b1.step_cnt), 32'(mcnt[1]));
`ifdef HASHER_TIME_CHECK_EN
    chk("time_err4", 32'(terr4), 32'(mterr));
    chk("time_err1", 32'(terr1), 32'(mterr));
`endif
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    chk("rst_ready4", 32'(b4.in_ready), 32'd0);
    chk("rst_ready1", 32'(b1.in_ready), 32'd0);
    check_outputs();
    rst = 1'b0;
  endtask

  // one clock: apply inputs, check ready, advance model, check registered outputs
  task automatic step(input logic s, input logic [W-1:0] sd, input logic v, input logic [W-1:0] t);
    logic         rdy, ok;
    longint       nv;
    drive(s, sd, v, t);
    #1;
    rdy = (mmode == 2) && !s;
    chk("in_ready4", 32'(b4.in_ready), 32'(rdy));
    chk("in_ready1", 32'(b1.in_ready), 32'(rdy));
    mov = 1'b0;
`ifdef HASHER_TIME_CHECK_EN
    ok = mfirst || (t > mlast);
`else
    ok = 1'b1;
`endif
    if (mmode == 1) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) mh[d][k] = mseed;
        mhash[d] = mseed; mcnt[d] = '0;
      end
      mlast = '0; mfirst = 1'b1; mterr = 1'b0;
      mmode = 2;
    end else if (s) begin
      mseed = sd;
      mmode = 1;
    end else if (mmode == 2 && v) begin
      if (ok) begin
        for (int d = 0; d < 2; d++) begin
          nv = (longint'(mh[d][depth[d]-1] ^ t) * MULT + longint'(mseed)) % (64'd1 << W);
          for (int k = depth[d] - 1; k > 0; k--) mh[d][k] = mh[d][k-1];
          mh[d][0] = W'(nv);
          mhash[d] = W'(nv);
          if (mcnt[d] != 16'hFFFF) mcnt[d] = mcnt[d] + 16'd1;
        end
        mov = 1'b1; mlast = t; mfirst = 1'b0;
      end else begin
        mterr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [W-1:0] tcur;
    drive(1'b0, '0, 1'b0, '0);
    do_reset(2);

    // seed 5, t=0,1 back-to-back
    step(1'b1, 16'd5, 1'b0, 16'd0);
    step(1'b0, 16'd0, 1'b0, 16'd0);
    chk("load_hash", 32'(b4.cur_hash), 32'd5);
    step(1'b0, 16'd0, 1'b1, 16'd0);
    chk("t0_hash4", 32'(b4.cur_hash), 32'd30);
    chk("t0_hash1", 32'(b1.cur_hash), 32'd30);
    step(1'b0, 16'd0, 1'b1, 16'd1);
    chk("t1_hash4", 32'(b4.cur_hash), 32'd25);
    chk("t1_hash1", 32'(b1.cur_hash), 32'd160);
    chk("t1_cnt", 32'(b4.step_cnt), 32'd2);

    // start beats a same-cycle sample
    step(1'b1, 16'd7, 1'b1, 16'd9);
    chk("start_nopulse", 32'(b4.out_valid), 32'd0);
    step(1'b0, 16'd0, 1'b1, 16'd10);
    chk("reload_hash", 32'(b4.cur_hash), 32'd7);
    chk("reload_cnt", 32'(b4.step_cnt), 32'd0);
    chk("reload_nopulse", 32'(b4.out_valid), 32'd0);

    // wrap-around
    step(1'b1, 16'hFFFF, 1'b0, 16'd0);
    step(1'b0, 16'd0, 1'b0, 16'd0);
    step(1'b0, 16'd0, 1'b1, 16'd0);
    chk("wrap_hash4", 32'(b4.cur_hash), 32'hFFFA);
    chk("wrap_hash1", 32'(b1.cur_hash), 32'hFFFA);

    // repeated time sample
    step(1'b1, 16'd1, 1'b0, 16'd0);
    step(1'b0, 16'd0, 1'b0, 16'd0);
    step(1'b0, 16'd0, 1'b1, 16'd3);
    step(1'b0, 16'd0, 1'b1, 16'd3);
`ifdef HASHER_TIME_CHECK_EN
    chk("dup_terr", 32'(terr4), 32'd1);
    chk("dup_cnt", 32'(b4.step_cnt), 32'd1);
    step(1'b1, 16'd2, 1'b0, 16'd0);
    step(1'b0, 16'd0, 1'b0, 16'd0);
    chk("dup_terr_clr", 32'(terr4), 32'd0);
`else
    chk("dup_cnt", 32'(b4.step_cnt), 32'd2);
`endif

    // mid-operation reset, then samples ignored in IDLE
    step(1'b0, 16'd0, 1'b1, 16'd40);
    do_reset(1);
    step(1'b0, 16'd0, 1'b1, 16'd50);

    // randomized traffic
    tcur = 16'd100;
    for (int c = 0; c < 400; c++) begin
      logic s, v;
      logic [W-1:0] t;
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        s = ($urandom_range(0, 24) == 0) || (mmode == 0 && $urandom_range(0, 3) == 0);
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) t = W'($urandom_range(0, 200));
        else begin
          tcur = tcur + W'($urandom_range(1, 300));
          t = tcur;
        end
        step(s, W'($urandom), v, t);
      end
    end

    // step_cnt saturation: 65535 increasing samples plus two more
    step(1'b1, 16'd0, 1'b0, 16'd0);
    step(1'b0, 16'd0, 1'b0, 16'd0);
    drive(1'b0, '0, 1'b1, '0);
    for (int i = 1; i <= 65537; i++) begin
      b4.cur_time = (i > 65535) ? 16'hFFFF : W'(i);
      b1.cur_time = b4.cur_time;
      @(posedge clk);
      #1;
    end
    chk("sat_cnt4", 32'(b4.step_cnt), 32'hFFFF);
    chk("sat_cnt1", 32'(b1.step_cnt), 32'hFFFF);
    do_reset(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
